// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and constants for the boot loader
package imem_boot_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int DEF_NUM_WORDS = 1024;
endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// byte_word_packer: assembles accepted bytes little-endian into a 32-bit word
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] k;
  assign word_valid = byte_en && k == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k    <= '0;
      word <= '0;
    end else if (clr) k <= '0;
    else if (byte_en) begin
      word[{k, 3'd0} +: 8] <= byte_data;
      k                    <= k + 2'd1;
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills instruction memory from a byte stream while holding the core
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [31:0]       checksum
);
  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(NUM_WORDS);
  state_t          state, nxt;
  logic [ADDR_W:0] count, idx;
  logic [31:0]     word;
  logic            word_valid, go, hs;
  assign go         = start && (state == IDLE || state == DONE);
  assign hs         = byte_valid && byte_ready;
  assign byte_ready = state == RECV;
  assign mem_we     = state == WRITE;
  assign cpu_hold   = state != DONE;
  assign load_done  = state == DONE;
  assign mem_wdata  = word;
  assign mem_addr   = 32'({idx[ADDR_W-1:0], 2'b00});
  byte_word_packer u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (go),
    .byte_en   (hs),
    .byte_data (byte_data),
    .word      (word),
    .word_valid(word_valid)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // idx is one bit wider than the address so count == NUM_WORDS ends without wrapping
  always_comb begin
    nxt = state;
    nxt = go ? (word_count == '0 ? DONE : RECV) :
          (state == RECV && word_valid) ? WRITE :
          state == WRITE ? (idx + (ADDR_W + 1)'(1) == count ? DONE : RECV) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count    <= '0;
      idx      <= '0;
      checksum <= '0;
    end else if (go) begin
      count    <= word_count > MAX_COUNT ? MAX_COUNT : word_count;
      idx      <= '0;
      checksum <= '0;
    end else if (state == WRITE) begin
      idx      <= idx + (ADDR_W + 1)'(1);
      checksum <= checksum + word;
    end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequencer that fills the instruction memory from a byte stream (e.g. UART receiver) before the core runs. It assembles little-endian bytes into 32-bit words and drives a synchronous write port on the instruction memory at consecutive word addresses. It holds the core's fetch stage stalled until the programmed word count has been written. Sits between the serial front end, the instruction memory write port and the core's stall input.

## Interface
- `NUM_WORDS`, 1024: instruction memory depth in words; also the maximum load length.
- `ADDR_W`, 10: word-index width, clog2(`NUM_WORDS`).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- `word_count` input ADDR_W+1: words to load, sampled on the accepted `start`.
- `byte_valid` input 1: stream byte available.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` output 32: byte address of write, word aligned ({idx, 2'b00}, zero-extended).
- `mem_wdata` output 32: assembled word.
- `cpu_hold` output 1: core fetch/PC held while 1.
- `load_done` output 1: level; last load completed.
- `checksum` output 32: modulo-2^32 sum of all words written in the current or last load.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- Reset values: state IDLE; `cpu_hold`=1, `byte_ready`=0, `mem_we`=0, `load_done`=0, `mem_addr`=0, `mem_wdata`=0, `checksum`=0, byte counter=0, word index=0.
- IDLE:
  - `cpu_hold`=1.
  - On `start`: latch count = min(`word_count`, `NUM_WORDS`), clear index, byte counter and checksum.
  - Go to RECV if count>0, else DONE.
- RECV:
  - `byte_ready`=1.
  - Each handshake (`byte_valid`&&`byte_ready`) writes `byte_data` into word lane [8k+7:8k] for byte counter k (k=0 first), then increments k.
  - On the 4th byte (k==3), go to WRITE and reset k to 0.
  - No handshake means state is held.
- WRITE:
  - `byte_ready`=0, `mem_we`=1, `mem_addr`={index,2'b00}, `mem_wdata`=assembled word.
  - `checksum` += word.
  - index+1; if index+1==count go to DONE, else RECV.
- DONE:
  - `cpu_hold`=0, `load_done`=1, `byte_ready`=0.
  - `start` re-enters the load exactly as in IDLE: `cpu_hold` goes to 1 and `load_done` to 0 the cycle after `start`.
- `start` in RECV/WRITE is ignored.
- `word_count` > `NUM_WORDS` is clamped; excess stream bytes are never accepted.
- Reset asserted mid-load returns everything to reset values at once. The partial word is discarded. Words already written stay in memory; memory is not cleared.

## Timing
- `byte_ready` is registered from state only; it does not depend on `byte_valid` combinationally.
- Minimum 5 cycles per word (4 accept + 1 WRITE). Load of N words with a continuously valid stream: `load_done` rises 5N+1 cycles after the `start` cycle.
- `mem_we` pulse lasts exactly one cycle. Address and data are valid in the same cycle as `mem_we`. The memory captures them on that edge.
- `cpu_hold` deasserts in the same cycle `load_done` asserts (first DONE cycle).
- Index arithmetic is ADDR_W+1 bits so that count==`NUM_WORDS` terminates without wrap. The final address is (`NUM_WORDS`-1)*4.

## Structure
- A shared package holds:
  - state encoding (2-bit enum IDLE=0, RECV=1, WRITE=2, DONE=3);
  - `NOP_INSN`=32'h0000_0013;
  - the default `NUM_WORDS`.
- One sub-module, `byte_word_packer`: byte counter plus little-endian shift/assemble, with `word_valid` output. The FSM and address/checksum counters live in the top level.

## Test plan
- Reset, no `start` -> `cpu_hold`=1, `load_done`=0, `mem_we` never pulses over 100 cycles.
- `start` with `word_count`=2, bytes 13 00 00 00 93 00 10 00 continuous -> writes 0x00000013 at addr 0x0, then 0x00100093 at addr 0x4. `load_done` at cycle 11. `checksum`=0x001000A6.
- Same load with `byte_valid` toggling every other cycle -> identical writes and checksum. `mem_we` only after 4th accepted byte.
- `word_count`=0 -> DONE the cycle after `start`. No writes. `cpu_hold`=0.
- `word_count`=2047 with `NUM_WORDS`=1024 -> exactly 1024 writes, last at 0xFFC. `byte_ready` stays 0 after.
- `rst_n` pulsed low after 2 bytes of word 1 -> outputs return to reset values immediately. A fresh `start` reloads from addr 0 with the new byte order intact.
